// File: rtl/fmac_norm_pipe_if.sv
// Valid/ready bus between the leading-zero anticipator, the normalization pipe
// and the rounding stage. The slave modport is the pipe's view; master is the
// view of whoever drives the inputs and consumes the outputs.
interface fmac_norm_pipe_if #(
  parameter int unsigned C_WIDTH         = 74,
  parameter int unsigned C_LEADONE_WIDTH = 7,
  parameter int unsigned C_EXP_WIDTH     = 10,
  parameter int unsigned C_MANT_WIDTH    = 24
) ();
  // Upstream side
  logic                       In_valid_SI;
  logic                       In_ready_SO;
  logic [C_WIDTH-1:0]         Sum_DI;
  logic [C_LEADONE_WIDTH-1:0] Lead_zero_DI;
  logic [C_EXP_WIDTH-1:0]     Exp_DI;
  logic                       Sign_DI;
  // Downstream side
  logic                       Out_valid_SO;
  logic                       Out_ready_SI;
  logic [C_MANT_WIDTH-1:0]    Mant_DO;
  logic                       Guard_SO;
  logic                       Sticky_SO;
  logic [C_EXP_WIDTH-1:0]     Exp_DO;
  logic                       Sign_SO;
  logic                       Zero_SO;
  logic                       Denorm_SO;

  modport slave (
    input  In_valid_SI, Sum_DI, Lead_zero_DI, Exp_DI, Sign_DI, Out_ready_SI,
    output In_ready_SO, Out_valid_SO, Mant_DO, Guard_SO, Sticky_SO, Exp_DO,
           Sign_SO, Zero_SO, Denorm_SO
  );

  modport master (
    output In_valid_SI, Sum_DI, Lead_zero_DI, Exp_DI, Sign_DI, Out_ready_SI,
    input  In_ready_SO, Out_valid_SO, Mant_DO, Guard_SO, Sticky_SO, Exp_DO,
           Sign_SO, Zero_SO, Denorm_SO
  );
endinterface

// File: rtl/fmac_norm_pipe.sv
// Two-stage elastic normalization pipe behind the FMAC leading-zero anticipator.
// Stage 1 applies the (clamped) anticipated shift; stage 2 fixes the anticipator's
// possible one-position under-estimate and extracts mantissa, guard and sticky.
module fmac_norm_pipe #(
  parameter int unsigned C_WIDTH         = 74,
  parameter int unsigned C_LEADONE_WIDTH = 7,
  parameter int unsigned C_EXP_WIDTH     = 10,
  parameter int unsigned C_MANT_WIDTH    = 24
) (
  input logic                Clk_CI,
  input logic                Rst_RI,
  input logic                Flush_SI,
  fmac_norm_pipe_if.slave    bus
);

  // Number of magnitude bits below the mantissa: guard is the top one.
  localparam int unsigned C_LOW = C_WIDTH - C_MANT_WIDTH;

  localparam logic [C_EXP_WIDTH-1:0]     C_EXP_ONE  = C_EXP_WIDTH'(1);
  localparam logic [C_EXP_WIDTH-1:0]     C_LZ_MAX_E = C_EXP_WIDTH'(C_WIDTH - 1);
  localparam logic [C_LEADONE_WIDTH-1:0] C_LZ_MAX   = C_LEADONE_WIDTH'(C_WIDTH - 1);

  // Handshake
  logic w_adv1, w_adv2, w_load1, w_load2;
  logic r_v1, r_v2;

  // Stage 1 combinational
  logic [C_EXP_WIDTH-1:0] w_lz, w_lim, w_s1, w_exp1;
  logic                   w_den1;

  // Stage 1 registers
  logic [C_WIDTH-1:0]     r_sum1;
  logic [C_EXP_WIDTH-1:0] r_exp1;
  logic                   r_den1, r_sign1, r_zero1;

  // Stage 2 combinational
  logic [C_WIDTH-1:0]     w_v;
  logic [C_EXP_WIDTH-1:0] w_exp2;
  logic                   w_den2, w_under;

  // Stage 2 registers
  logic [C_MANT_WIDTH-1:0] r_mant;
  logic [C_EXP_WIDTH-1:0]  r_exp2;
  logic                    r_guard, r_sticky, r_sign2, r_zero2, r_den2;

  // Elastic control: a stage moves when it is empty or its successor moves.
  always_comb begin
    w_adv2  = ~r_v2 | bus.Out_ready_SI;
    w_adv1  = ~r_v1 | w_adv2;
    // Flush also freezes the data registers so flushed beats leave no trace.
    w_load1 = w_adv1 & bus.In_valid_SI & ~Flush_SI;
    w_load2 = w_adv2 & r_v1 & ~Flush_SI;
  end

  // Coarse shift amount, clamped so the exponent never drops below 1.
  always_comb begin
    w_lz = (bus.Lead_zero_DI > C_LZ_MAX) ? C_LZ_MAX_E : C_EXP_WIDTH'(bus.Lead_zero_DI);
    w_lim = ($signed(bus.Exp_DI) > $signed(C_EXP_ONE)) ? (bus.Exp_DI - C_EXP_ONE)
                                                       : '0;
    // Both operands are non-negative here, so an unsigned compare is exact.
    w_den1 = (w_lz > w_lim);
    w_s1   = w_den1 ? w_lim : w_lz;
    w_exp1 = bus.Exp_DI - w_s1;
  end

  // Correction for the anticipator's one-position under-estimate.
  always_comb begin
    w_v     = r_sum1;
    w_exp2  = r_exp1;
    w_den2  = 1'b0;
    w_under = ~r_sum1[C_WIDTH-1] & ~r_den1 & ~r_zero1;
    if (r_zero1) begin
      w_v    = '0;
      w_exp2 = '0;
    end else if (r_den1) begin
      w_exp2 = '0;
      w_den2 = 1'b1;
    end else if (w_under && ($signed(r_exp1) > $signed(C_EXP_ONE))) begin
      w_v    = r_sum1 << 1;
      w_exp2 = r_exp1 - C_EXP_ONE;
    end else if (w_under && (r_exp1 == C_EXP_ONE)) begin
      // One more shift would need exponent 0: result is subnormal instead.
      w_exp2 = '0;
      w_den2 = 1'b1;
    end
  end

  // Valid bits: reset beats flush, flush beats an input transfer.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || Flush_SI) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_adv1) r_v1 <= bus.In_valid_SI;
      if (w_adv2) r_v2 <= r_v1;
    end
  end

  // Stage 1 data registers.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_sum1  <= '0;
      r_exp1  <= '0;
      r_den1  <= 1'b0;
      r_sign1 <= 1'b0;
      r_zero1 <= 1'b0;
    end else if (w_load1) begin
      r_sum1  <= bus.Sum_DI << w_s1;
      r_exp1  <= w_exp1;
      r_den1  <= w_den1;
      r_sign1 <= bus.Sign_DI;
      r_zero1 <= ~|bus.Sum_DI;
    end
  end

  // Stage 2 data registers; these drive the outputs directly.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_mant   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_exp2   <= '0;
      r_sign2  <= 1'b0;
      r_zero2  <= 1'b0;
      r_den2   <= 1'b0;
    end else if (w_load2) begin
      r_mant   <= w_v[C_WIDTH-1 -: C_MANT_WIDTH];
      r_guard  <= w_v[C_LOW-1];
      r_sticky <= |w_v[C_LOW-2:0];
      r_exp2   <= w_exp2;
      r_sign2  <= r_sign1;
      r_zero2  <= r_zero1;
      r_den2   <= w_den2;
    end
  end

  // Output drive.
  always_comb begin
    bus.In_ready_SO  = w_adv1;
    bus.Out_valid_SO = r_v2;
    bus.Mant_DO      = r_mant;
    bus.Guard_SO     = r_guard;
    bus.Sticky_SO    = r_sticky;
    bus.Exp_DO       = r_exp2;
    bus.Sign_SO      = r_sign2;
    bus.Zero_SO      = r_zero2;
    bus.Denorm_SO    = r_den2;
  end

endmodule

// File: doc/fmac_norm_pipe.md
# fmac_norm_pipe

Two-stage elastic normalization pipeline that sits directly downstream of the FMAC leading-zero anticipator. It consumes the adder magnitude, the anticipated leading-zero count and the pre-normalization exponent. It left-shifts the magnitude, corrects the anticipator's one-position under-estimate, clamps the shift at the subnormal boundary, and hands mantissa, guard and sticky bits plus the adjusted exponent to the rounding stage over a valid/ready handshake.

## Interface
- C_WIDTH, 74: adder magnitude width; must equal the anticipator's operand width.
- C_LEADONE_WIDTH, 7: leading-zero count width, ceil(log2(C_WIDTH)).
- C_EXP_WIDTH, 10: signed exponent width.
- C_MANT_WIDTH, 24: output mantissa width, hidden bit included.

Ports:
- Clk_CI  in  1  clock; single clock domain.
- Rst_RI  in  1  reset; synchronous, active-high.
- Flush_SI  in  1  synchronous pipeline flush.
- In_valid_SI  in  1  input beat valid.
- In_ready_SO  out  1  stage accepts input.
- Sum_DI  in  C_WIDTH  unsigned adder magnitude; bit C_WIDTH-1 carries weight 2^Exp_DI.
- Lead_zero_DI  in  C_LEADONE_WIDTH  anticipated leading-zero count from the MSB.
- Exp_DI  in  C_EXP_WIDTH  signed exponent of Sum_DI bit C_WIDTH-1.
- Sign_DI  in  1  result sign; passed through unchanged.
- Out_valid_SO  out  1  output beat valid.
- Out_ready_SI  in  1  downstream accepts output.
- Mant_DO  out  C_MANT_WIDTH  normalized mantissa.
- Guard_SO  out  1  first bit below the mantissa.
- Sticky_SO  out  1  OR of all remaining lower bits.
- Exp_DO  out  C_EXP_WIDTH  adjusted exponent; 0 means subnormal.
- Sign_SO  out  1  registered sign.
- Zero_SO  out  1  Sum_DI was all-zero.
- Denorm_SO  out  1  shift was limited by the exponent floor.

## Operation
- Stage 1, coarse shift:
  - Saturate Lead_zero_DI to C_WIDTH-1.
  - Compute lim = max(Exp_DI-1, 0).
  - s1 = min(LZ, lim); den1 = (LZ > lim).
  - Register Sum_DI<<s1, Exp_DI-s1, den1, Sign_DI, and zero = (Sum_DI==0).
- Stage 2, correction:
  - The anticipator is exact or under-estimates by exactly one.
  - If the shifted MSB is 0, den1 is 0, zero is 0, and Exp1 > 1: shift left one more and subtract one from the exponent.
  - If the shifted MSB is 0, den1 is 0, zero is 0, and Exp1 == 1: no shift, Exp_DO = 0, Denorm_SO = 1.
  - If den1 is 1: Exp_DO = 0 and Denorm_SO = 1.
  - Otherwise Exp_DO is the stage-1 exponent, with correction applied if any.
- Output extraction from the final shifted value V:
  - Mant_DO = V[C_WIDTH-1 -: C_MANT_WIDTH].
  - Guard_SO = next lower bit.
  - Sticky_SO = OR of all bits below the guard bit.
- Zero input: Mant_DO, Guard_SO, Sticky_SO and Exp_DO are all 0; Zero_SO = 1; Denorm_SO = 0.
- Exponent arithmetic is C_EXP_WIDTH two's complement. Callers guarantee Exp_DI is no larger than 2^(C_EXP_WIDTH-1)-1.
- Elastic pipeline, one valid bit per stage (V1, V2):
  - adv2 = ~V2 | Out_ready_SI.
  - adv1 = ~V1 | adv2.
  - In_ready_SO = adv1.
  - A stage's data registers load only when that stage advances. Held data is stable while stalled.
- Out_valid_SO = V2. All outputs are driven directly from stage-2 registers; no combinational path from inputs.

## Timing
- Latency: 2 cycles from accepted input to Out_valid_SO with no backpressure.
- Throughput: 1 beat per cycle.
- Valid/ready rules:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - Out_valid_SO and all output data hold until accepted.
  - In_ready_SO may depend combinationally on Out_ready_SI.
- Full pipeline with Out_ready_SI low: In_ready_SO = 0, and no beat is lost or duplicated.
- Out_ready_SI high while both stages are full: both stages advance and a new beat is accepted in the same cycle.
- Reset (Rst_RI high at an edge): V1 = V2 = 0, so Out_valid_SO = 0. All data registers and outputs reset to 0 (Mant_DO, Guard_SO, Sticky_SO, Exp_DO, Sign_SO, Zero_SO, Denorm_SO). In-flight beats are dropped.
- Flush_SI: clears V1 and V2 at the edge and takes priority over an input transfer in the same cycle; data registers keep their values.
- Reset has priority over flush.

## Test plan
- Exact anticipation: Sum = 1<<60, LZ = 13, Exp = 100 -> after 2 cycles Mant = 0x800000, G = 0, S = 0, Exp = 87, Zero = 0, Denorm = 0.
- Under-estimate: Sum = 1<<60, LZ = 12, Exp = 100 -> same result as the exact case (correction applied).
- Guard/sticky: Sum = (1<<73)|(1<<49)|1, LZ = 0, Exp = 5 -> Mant = 0x800000, G = 1, S = 1, Exp = 5.
- Subnormal clamp: Sum = 1<<60, LZ = 13, Exp = 5 -> shift 4, Mant = 0x004000, Exp = 0, Denorm = 1.
- Zero: Sum = 0, LZ = 73, Exp = 40 -> Zero = 1, Mant = 0, Exp = 0, Denorm = 0.
- Handshake/flush:
  - Stream 8 beats with Out_ready toggling every cycle: all 8 arrive in order, none dropped or duplicated, outputs stable while stalled.
  - Assert Flush with 2 beats in flight: Out_valid = 0 the next cycle.
  - Assert Rst_RI mid-stream: every output is 0 the next cycle.
